// File: rtl/wrapper_pkg.sv
// Shared types, widths and helpers for the game-wrapper layer.
package wrapper_pkg;

    localparam int unsigned MAX_GAMES = 4;
    localparam int unsigned ACT_W     = 2;
    localparam int unsigned FRM_W     = 4;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_VS = 2'd1,
        BLANK   = 2'd2
    } state_e;

    // Round-robin successor of idx among n cores.
    function automatic logic [ACT_W-1:0] next_idx(input logic [ACT_W-1:0] idx,
                                                  input int unsigned      n);
        if (32'(idx) + 32'd1 >= n) return '0;
        return idx + ACT_W'(1);
    endfunction

endpackage

// File: rtl/wrapper_debounce.sv
// Button conditioner: 2-flop synchronizer, level debounce, one-cycle rising-edge pulse.
module wrapper_debounce #(
    parameter int unsigned DEB_CYCLES = 65536
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

    logic [1:0]       sync_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;

    // A new level is accepted only after it differs from the stable level for DEB_CYCLES cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            pulse  <= 1'b0;
            if (sync_q[1] == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                cnt_q    <= '0;
                stable_q <= sync_q[1];
                pulse    <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/wrapper_game_mux.sv
// Frame-synchronous VGA/key ownership scheduler for up to four game cores.
// Optional: WRAPPER_GAME_MUX_HOLD_RESET_EN holds every non-owning core in reset.
module wrapper_game_mux
    import wrapper_pkg::*;
#(
    parameter int unsigned NUM_GAMES    = 2,
    parameter int unsigned DEB_CYCLES   = 65536,
    parameter int unsigned BLANK_FRAMES = 2,
    parameter int unsigned VS_TIMEOUT   = 1048576,
    parameter bit          SYNC_POL     = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             keys,
    input  logic                   next_btn,
    input  logic [NUM_GAMES-1:0]   core_hsync,
    input  logic [NUM_GAMES-1:0]   core_vsync,
    input  logic [3*NUM_GAMES-1:0] core_rgb,
    output logic [4*NUM_GAMES-1:0] core_keys,
    output logic [NUM_GAMES-1:0]   core_reset,
    output logic                   hsync,
    output logic                   vsync,
    output logic [2:0]             rgb,
    output logic [1:0]             active
);

    localparam int unsigned TO_W      = $clog2(VS_TIMEOUT + 1);
    localparam int unsigned RGB_ALL_W = 3 * MAX_GAMES;
    localparam int unsigned KEY_W     = 4 * NUM_GAMES;

    state_e               state_q, state_d;
    logic [ACT_W-1:0]     active_q, active_d;
    logic [FRM_W-1:0]     frm_cnt_q;
    logic [TO_W-1:0]      to_cnt_q;
    logic                 vs_s_q, vs_d_q;
    logic                 req_c, edge_c, switch_c;
    logic [MAX_GAMES-1:0] hs_all, vs_all;
    logic [RGB_ALL_W-1:0] rgb_all;
    logic [2:0]           rgb_arr [MAX_GAMES];
    logic                 hsync_d, vsync_d;
    logic [2:0]           rgb_d;
    logic [KEY_W-1:0]     keys_d;

    wrapper_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_next_deb (
        .clk   (clk),
        .reset (reset),
        .btn   (next_btn),
        .pulse (req_c)
    );

    // Pad core buses to four slots so a 2-bit owner index never selects out of range.
    assign hs_all  = MAX_GAMES'(core_hsync);
    assign vs_all  = MAX_GAMES'(core_vsync);
    assign rgb_all = RGB_ALL_W'(core_rgb);
    for (genvar g = 0; g < MAX_GAMES; g++) begin : g_rgb
        assign rgb_arr[g] = rgb_all[3*g +: 3];
    end

    assign edge_c = vs_s_q & ~vs_d_q;
    assign active = active_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        switch_c = 1'b0;
        case (state_q)
            RUN: begin
                if (req_c) state_d = WAIT_VS;
            end
            WAIT_VS: begin
                if (edge_c || to_cnt_q == TO_W'(VS_TIMEOUT - 1)) begin
                    switch_c = 1'b1;
                    active_d = next_idx(active_q, NUM_GAMES);
                    state_d  = BLANK;
                end
            end
            BLANK: begin
                if (edge_c && frm_cnt_q == FRM_W'(BLANK_FRAMES - 1)) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        hsync_d = hs_all[active_q];
        vsync_d = vs_all[active_q];
        rgb_d   = rgb_arr[active_q];
        keys_d  = KEY_W'(keys) << {active_q, 2'b00};
        if (state_q == BLANK) begin
            rgb_d  = '0;
            keys_d = '0;
        end
    end

    // Edge detector reloads with the incoming core's level on the switch so no stale edge is seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_s_q    <= 1'b0;
            vs_d_q    <= 1'b0;
            frm_cnt_q <= '0;
            to_cnt_q  <= '0;
            hsync     <= ~SYNC_POL;
            vsync     <= ~SYNC_POL;
            rgb       <= '0;
            core_keys <= '0;
        end else begin
            if (switch_c) begin
                vs_s_q <= (vs_all[active_d] == SYNC_POL);
                vs_d_q <= (vs_all[active_d] == SYNC_POL);
            end else begin
                vs_s_q <= (vs_all[active_q] == SYNC_POL);
                vs_d_q <= vs_s_q;
            end
            if (switch_c) frm_cnt_q <= '0;
            else if (state_q == BLANK && edge_c) frm_cnt_q <= frm_cnt_q + FRM_W'(1);
            if (state_q == WAIT_VS && !switch_c) to_cnt_q <= to_cnt_q + TO_W'(1);
            else to_cnt_q <= '0;
            hsync     <= hsync_d;
            vsync     <= vsync_d;
            rgb       <= rgb_d;
            core_keys <= keys_d;
        end
    end

`ifdef WRAPPER_GAME_MUX_HOLD_RESET_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) core_reset <= '1;
        else       core_reset <= ~(NUM_GAMES'(1) << active_d);
    end
`else
    assign core_reset = {NUM_GAMES{reset}};
`endif

endmodule

// File: tb/tb_wrapper_game_mux.sv
// Directed self-checking bench for wrapper_game_mux (2 cores, short debounce and timeout).
module tb_wrapper_game_mux;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] keys;
    logic       next_btn;
    logic [1:0] core_hsync, core_vsync;
    logic [5:0] core_rgb;
    logic [7:0] core_keys;
    logic [1:0] core_reset;
    logic       hsync, vsync;
    logic [2:0] rgb;
    logic [1:0] active;

    int checks = 0;
    int errors = 0;

`ifdef WRAPPER_GAME_MUX_HOLD_RESET_EN
    localparam logic [1:0] RST_RUN0 = 2'b10;
    localparam logic [1:0] RST_RUN1 = 2'b01;
`else
    localparam logic [1:0] RST_RUN0 = 2'b00;
    localparam logic [1:0] RST_RUN1 = 2'b00;
`endif

    wrapper_game_mux #(
        .NUM_GAMES    (2),
        .DEB_CYCLES   (4),
        .BLANK_FRAMES (2),
        .VS_TIMEOUT   (64),
        .SYNC_POL     (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .keys       (keys),
        .next_btn   (next_btn),
        .core_hsync (core_hsync),
        .core_vsync (core_vsync),
        .core_rgb   (core_rgb),
        .core_keys  (core_keys),
        .core_reset (core_reset),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb),
        .active     (active)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input int n);
        next_btn = 1'b1;
        tick(n);
        next_btn = 1'b0;
    endtask

    task automatic vs1_pulse();
        core_vsync[1] = 1'b1;
        tick(3);
        core_vsync[1] = 1'b0;
        tick(5);
    endtask

    initial begin
        int  k;
        bit  found;

        reset      = 1'b1;
        keys       = 4'b0011;
        next_btn   = 1'b0;
        core_hsync = 2'b01;
        core_vsync = 2'b00;
        core_rgb   = {3'b101, 3'b011};
        tick(3);
        check("rst_active", 32'(active), 32'd0);
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_hsync", 32'(hsync), 32'd0);
        check("rst_vsync", 32'(vsync), 32'd0);
        check("rst_core_reset", 32'(core_reset), 32'h3);
        check("rst_core_keys", 32'(core_keys), 32'h0);

        reset = 1'b0;
        tick(1);
        check("run_rgb0", 32'(rgb), 32'h3);
        check("run_hsync0", 32'(hsync), 32'h1);
        check("run_core_keys0", 32'(core_keys), 32'h03);
        check("run_core_reset0", 32'(core_reset), 32'(RST_RUN0));
        core_rgb[2:0] = 3'b110;
        #1;
        check("rgb_reg_hold", 32'(rgb), 32'h3);
        tick(1);
        check("rgb_reg_follow", 32'(rgb), 32'h6);
        core_rgb[2:0] = 3'b011;

        // Short glitches must never reach the debounced request.
        for (int i = 0; i < 4; i++) begin
            press(1);
            tick(1);
        end
        tick(80);
        check("bounce_active", 32'(active), 32'd0);

        // Real press: still core 0 until its vsync edge.
        press(8);
        tick(40);
        check("waitvs_active", 32'(active), 32'd0);
        check("waitvs_rgb", 32'(rgb), 32'h3);
        core_vsync[0] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick(1);
            if (active == 2'd1) found = 1'b1;
        end
        check("switch_on_vsync", 32'(found), 32'd1);
        core_vsync[0] = 1'b0;
        tick(1);
        check("blank_rgb", 32'(rgb), 32'h0);
        check("blank_hsync_core1", 32'(hsync), 32'h0);
        check("blank_core_keys", 32'(core_keys), 32'h0);
        check("blank_core_reset", 32'(core_reset), 32'(RST_RUN1));

        vs1_pulse();
        check("blank_after_edge1", 32'(rgb), 32'h0);
        press(8);
        tick(6);
        check("blank_press_active", 32'(active), 32'd1);
        vs1_pulse();
        check("run1_rgb", 32'(rgb), 32'h5);
        check("run1_core_keys", 32'(core_keys), 32'h30);
        tick(80);
        check("no_queued_req", 32'(active), 32'd1);

        // core 1 vsync stays low: timeout forces the switch.
        next_btn = 1'b1;
        k = 0;
        found = 1'b0;
        for (int i = 1; i <= 200 && !found; i++) begin
            tick(1);
            if (i == 8) next_btn = 1'b0;
            if (active != 2'd1) begin
                found = 1'b1;
                k = i;
            end
        end
        next_btn = 1'b0;
        check("timeout_switch", 32'(found), 32'd1);
        check("timeout_window", 32'(k >= 66 && k <= 80), 32'd1);
        check("timeout_wrap", 32'(active), 32'd0);
        tick(3);
        check("timeout_blank_rgb", 32'(rgb), 32'h0);

        // Reset in the middle of BLANK.
        reset = 1'b1;
        #1;
        check("midrst_active", 32'(active), 32'd0);
        check("midrst_rgb", 32'(rgb), 32'h0);
        check("midrst_core_keys", 32'(core_keys), 32'h0);
        check("midrst_core_reset", 32'(core_reset), 32'h3);
        tick(2);
        reset = 1'b0;
        tick(1);
        check("postrst_rgb", 32'(rgb), 32'h3);
        check("postrst_core_keys", 32'(core_keys), 32'h03);
        check("postrst_core_reset", 32'(core_reset), 32'(RST_RUN0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
